// File: rtl/nfmac10g_tx_arb.sv
// rtl/nfmac10g_tx_arb.sv - two-source packet-granular round-robin arbiter for the MAC Tx stream
module nfmac10g_tx_arb #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                tx_axis_aresetn,

    input  logic [DATA_W-1:0]   s0_axis_tdata,
    input  logic [DATA_W/8-1:0] s0_axis_tkeep,
    input  logic                s0_axis_tvalid,
    output logic                s0_axis_tready,
    input  logic                s0_axis_tlast,
    input  logic                s0_axis_tuser,

    input  logic [DATA_W-1:0]   s1_axis_tdata,
    input  logic [DATA_W/8-1:0] s1_axis_tkeep,
    input  logic                s1_axis_tvalid,
    output logic                s1_axis_tready,
    input  logic                s1_axis_tlast,
    input  logic                s1_axis_tuser,

    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                m_axis_tuser,

    output logic                busy,
    output logic                cur_src,
    output logic [CNT_W-1:0]    s0_pkts,
    output logic [CNT_W-1:0]    s1_pkts,
    output logic [CNT_W-1:0]    s0_aborts,
    output logic [CNT_W-1:0]    s1_aborts
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   cur_src_nxt;

    logic [DATA_W-1:0]   sel_tdata;
    logic [DATA_W/8-1:0] sel_tkeep;
    logic                sel_tvalid;
    logic                sel_tlast;
    logic                sel_tuser;
    logic                frame_done;

    // Mux of the locked source; only reaches m_axis while in XFER.
    assign sel_tdata  = cur_src ? s1_axis_tdata  : s0_axis_tdata;
    assign sel_tkeep  = cur_src ? s1_axis_tkeep  : s0_axis_tkeep;
    assign sel_tvalid = cur_src ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_tlast  = cur_src ? s1_axis_tlast  : s0_axis_tlast;
    assign sel_tuser  = cur_src ? s1_axis_tuser  : s0_axis_tuser;

    assign frame_done = (state == XFER) && sel_tvalid && m_axis_tready && sel_tlast;
    assign busy       = (state == XFER);

    always_ff @(posedge clk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            state   <= IDLE;
            cur_src <= 1'b1;
        end else begin
            state   <= state_nxt;
            cur_src <= cur_src_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cur_src_nxt    = cur_src;
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state)
            IDLE: begin
                // Arbitration cycle: no beat moves, the winner is latched for the whole frame.
                if (s0_axis_tvalid && s1_axis_tvalid) begin
                    cur_src_nxt = ~cur_src;
                    state_nxt   = XFER;
                end else if (s0_axis_tvalid) begin
                    cur_src_nxt = 1'b0;
                    state_nxt   = XFER;
                end else if (s1_axis_tvalid) begin
                    cur_src_nxt = 1'b1;
                    state_nxt   = XFER;
                end
            end
            XFER: begin
                m_axis_tdata  = sel_tdata;
                m_axis_tkeep  = sel_tkeep;
                m_axis_tvalid = sel_tvalid;
                m_axis_tlast  = sel_tlast;
                m_axis_tuser  = sel_tuser;
                if (cur_src) begin
                    s1_axis_tready = m_axis_tready;
                end else begin
                    s0_axis_tready = m_axis_tready;
                end
                if (frame_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            s0_pkts   <= '0;
            s1_pkts   <= '0;
            s0_aborts <= '0;
            s1_aborts <= '0;
        end else if (frame_done) begin
            if (cur_src) begin
                s1_pkts <= s1_pkts + CNT_W'(1);
                if (sel_tuser) begin
                    s1_aborts <= s1_aborts + CNT_W'(1);
                end
            end else begin
                s0_pkts <= s0_pkts + CNT_W'(1);
                if (sel_tuser) begin
                    s0_aborts <= s0_aborts + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_nfmac10g_tx_arb.sv
// tb/tb_nfmac10g_tx_arb.sv - randomized self-checking bench for nfmac10g_tx_arb
module tb_nfmac10g_tx_arb;

    localparam int DATA_W = 64;
    localparam int KEEP_W = DATA_W / 8;
    localparam int CNT_W  = 32;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic              user;
    } beat_t;

    logic              clk = 1'b0;
    logic              tx_axis_aresetn;
    logic [DATA_W-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic [KEEP_W-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
    logic              s0_axis_tvalid, s0_axis_tready, s0_axis_tlast, s0_axis_tuser;
    logic              s1_axis_tvalid, s1_axis_tready, s1_axis_tlast, s1_axis_tuser;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic              busy, cur_src;
    logic [CNT_W-1:0]  s0_pkts, s1_pkts, s0_aborts, s1_aborts;

    nfmac10g_tx_arb #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .tx_axis_aresetn(tx_axis_aresetn),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tready(s0_axis_tready), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tready(s1_axis_tready), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .busy(busy), .cur_src(cur_src),
        .s0_pkts(s0_pkts), .s1_pkts(s1_pkts), .s0_aborts(s0_aborts), .s1_aborts(s1_aborts)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-source frame stores and the expected MAC-side beat stream.
    beat_t q0[$], q1[$], expq[$];
    int    fl0[$], fl1[$];
    int    exp_pkts[2], exp_aborts[2];
    int    last_grant;
    int    frame_id = 0;

    task automatic model_clear();
        q0.delete(); q1.delete(); expq.delete(); fl0.delete(); fl1.delete();
        exp_pkts[0] = 0; exp_pkts[1] = 0; exp_aborts[0] = 0; exp_aborts[1] = 0;
        last_grant = 1;
    endtask

    task automatic gen_frame(input int src, input int len, input bit abort, input bit user_noise);
        beat_t b;
        frame_id++;
        for (int i = 0; i < len; i++) begin
            b.data = {src[0], 15'(frame_id), 16'(i), 32'($urandom)};
            b.keep = KEEP_W'($urandom_range(1, (1 << KEEP_W) - 1));
            b.last = (i == len - 1);
            b.user = b.last ? abort : (user_noise ? 1'($urandom) : 1'b0);
            if (src == 0) q0.push_back(b); else q1.push_back(b);
        end
        if (src == 0) fl0.push_back(len); else fl1.push_back(len);
    endtask

    // Packet-level round robin: with both sources pending, the one not granted last wins.
    task automatic build_order();
        int p0 = 0, p1 = 0, f0 = 0, f1 = 0, pick, len;
        beat_t b;
        expq.delete();
        while (f0 < fl0.size() || f1 < fl1.size()) begin
            if (f0 < fl0.size() && f1 < fl1.size()) pick = (last_grant == 0) ? 1 : 0;
            else pick = (f0 < fl0.size()) ? 0 : 1;
            len = (pick == 0) ? fl0[f0] : fl1[f1];
            for (int j = 0; j < len; j++) begin
                b = (pick == 0) ? q0[p0 + j] : q1[p1 + j];
                expq.push_back(b);
                if (b.last) begin
                    exp_pkts[pick]++;
                    if (b.user) exp_aborts[pick]++;
                end
            end
            if (pick == 0) begin p0 += len; f0++; end else begin p1 += len; f1++; end
            last_grant = pick;
        end
    endtask

    task automatic idle_inputs();
        s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tvalid = 0; s0_axis_tlast = 0; s0_axis_tuser = 0;
        s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tvalid = 0; s1_axis_tlast = 0; s1_axis_tuser = 0;
        m_axis_tready = 0;
    endtask

    task automatic check_counters(input string tag);
        checks++;
        if (s0_pkts !== CNT_W'(exp_pkts[0]) || s1_pkts !== CNT_W'(exp_pkts[1])) begin
            errors++;
            $display("FAIL %s pkts: got s0=%0d s1=%0d expected s0=%0d s1=%0d", tag, s0_pkts, s1_pkts, exp_pkts[0], exp_pkts[1]);
        end
        checks++;
        if (s0_aborts !== CNT_W'(exp_aborts[0]) || s1_aborts !== CNT_W'(exp_aborts[1])) begin
            errors++;
            $display("FAIL %s aborts: got s0=%0d s1=%0d expected s0=%0d s1=%0d", tag, s0_aborts, s1_aborts, exp_aborts[0], exp_aborts[1]);
        end
    endtask

    // ready_mode: 0 always ready, 1 toggling, 2 random 70%. strict_gap demands exactly one idle cycle per frame.
    task automatic run_traffic(input string tag, input int ready_mode, input int gap_pct,
                               input bit strict_gap, input int stop_after);
        int i0 = 0, i1 = 0, k = 0, cycle = 0, last_tlast_cyc = -1;
        bit hs0, hs1, first0, first1, exp_src;
        beat_t got;
        build_order();
        while (k < expq.size() && cycle < 20000) begin
            first0 = (i0 == 0) || (i0 < q0.size() && q0[i0 - 1].last);
            first1 = (i1 == 0) || (i1 < q1.size() && q1[i1 - 1].last);
            if (i0 < q0.size()) begin
                {s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast, s0_axis_tuser} = q0[i0];
                s0_axis_tvalid = first0 || ($urandom_range(0, 99) >= gap_pct);
            end else begin
                s0_axis_tvalid = 0;
            end
            if (i1 < q1.size()) begin
                {s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast, s1_axis_tuser} = q1[i1];
                s1_axis_tvalid = first1 || ($urandom_range(0, 99) >= gap_pct);
            end else begin
                s1_axis_tvalid = 0;
            end
            case (ready_mode)
                0: m_axis_tready = 1;
                1: m_axis_tready = cycle[0];
                default: m_axis_tready = ($urandom_range(0, 99) < 70);
            endcase
            @(negedge clk);
            if (stop_after > 0 && k == stop_after) return;
            hs0 = s0_axis_tvalid && s0_axis_tready;
            hs1 = s1_axis_tvalid && s1_axis_tready;
            exp_src = expq[k].data[DATA_W-1];
            checks++;
            if ((exp_src ? s0_axis_tready : s1_axis_tready) !== 1'b0) begin
                errors++;
                $display("FAIL %s lock: non-granted source %0d has tready=1 at beat %0d", tag, !exp_src, k);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
                checks++;
                if (got !== expq[k]) begin
                    errors++;
                    $display("FAIL %s beat %0d: got %h expected %h", tag, k, got, expq[k]);
                end
                if ((k == 0 || expq[k - 1].last) && last_tlast_cyc >= 0) begin
                    checks++;
                    if (strict_gap ? (cycle - last_tlast_cyc != 2) : (cycle - last_tlast_cyc < 2)) begin
                        errors++;
                        $display("FAIL %s bubble: frame start %0d cycles after tlast, expected %s2", tag,
                                 cycle - last_tlast_cyc, strict_gap ? "" : ">=");
                    end
                end
                if (m_axis_tlast) last_tlast_cyc = cycle;
                k++;
            end
            @(posedge clk); #1;
            if (hs0) i0++;
            if (hs1) i1++;
            cycle++;
        end
        checks++;
        if (k != expq.size()) begin
            errors++;
            $display("FAIL %s timeout: got %0d beats expected %0d", tag, k, expq.size());
        end
        idle_inputs();
        check_counters(tag);
        checks++;
        if (busy !== 1'b0 || cur_src !== 1'(last_grant)) begin
            errors++;
            $display("FAIL %s end state: got busy=%b cur_src=%b expected busy=0 cur_src=%0d", tag, busy, cur_src, last_grant);
        end
        q0.delete(); q1.delete(); fl0.delete(); fl1.delete(); expq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (m_axis_tvalid !== 0 || busy !== 0 || cur_src !== 1 || s0_axis_tready !== 0 || s1_axis_tready !== 0 ||
            m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 0 || m_axis_tuser !== 0) begin
            errors++;
            $display("FAIL %s outputs: got mvalid=%b busy=%b cur_src=%b rdy=%b%b mdata=%h expected 0,0,1,00,0",
                     tag, m_axis_tvalid, busy, cur_src, s0_axis_tready, s1_axis_tready, m_axis_tdata);
        end
        check_counters(tag);
    endtask

    task automatic test_reset();
        idle_inputs();
        model_clear();
        tx_axis_aresetn = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tx_axis_aresetn = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_reset_outputs("reset_idle");
        end
    endtask

    task automatic test_s0_only();
        for (int f = 0; f < 3; f++) gen_frame(0, 8, 0, 1);
        run_traffic("s0_only", 0, 0, 1, 0);
    endtask

    task automatic test_round_robin();
        for (int f = 0; f < 5; f++) begin
            gen_frame(0, 4, 0, 0);
            gen_frame(1, 4, 0, 0);
        end
        run_traffic("round_robin", 0, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        gen_frame(0, 3, 0, 0);
        gen_frame(1, 5, 0, 1);
        gen_frame(0, 3, 0, 0);
        run_traffic("backpressure", 1, 0, 0, 0);
    endtask

    task automatic test_aborts();
        gen_frame(0, 4, 1, 0);
        gen_frame(0, 4, 0, 0);
        run_traffic("aborts", 0, 0, 1, 0);
    endtask

    task automatic test_single_beat();
        gen_frame(0, 1, 0, 0);
        gen_frame(0, 1, 1, 0);
        gen_frame(1, 1, 0, 0);
        run_traffic("single_beat", 0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int f = 0; f < 6; f++) begin
                gen_frame($urandom_range(0, 1), $urandom_range(1, 9), 1'($urandom_range(0, 3) == 0), 1);
            end
            run_traffic("random", 2, 25, 0, 0);
        end
    endtask

    task automatic test_reset_mid_frame();
        gen_frame(1, 10, 0, 0);
        run_traffic("mid_frame", 0, 0, 1, 2);
        tx_axis_aresetn = 0;
        #1;
        model_clear();
        check_reset_outputs("mid_frame_reset");
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tx_axis_aresetn = 1;
        @(posedge clk); #1;
        gen_frame(1, 3, 0, 0);
        gen_frame(0, 3, 0, 0);
        run_traffic("after_reset", 0, 0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_s0_only();
        test_round_robin();
        test_backpressure();
        test_aborts();
        test_single_beat();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
